// File: rtl/cdc_bus_rx.sv
// cdc_bus_rx
// ----------
// Receive side of a toggle request/acknowledge bus crossing. The source holds
// data_i stable, then flips req_tgl_i. This block synchronizes the toggle,
// captures the word on the detected edge, and offers the word downstream with a
// valid/ready handshake. When the word is accepted, it flips ack_tgl_o so the
// source may launch the next word.
//
// Parameters
//   Width      data bus width in bits (>= 1)
//
// Ports
//   clk_i      destination-domain clock
//   rst_i      synchronous, active-high reset
//   req_tgl_i  request toggle from the source domain (asynchronous)
//   data_i     source data bus, stable while a request is outstanding
//   ack_tgl_o  acknowledge toggle back to the source domain (registered)
//   data_o     captured word
//   valid_o    data_o holds a word that has not been accepted yet
//   ready_i    downstream accepts the word when high together with valid_o
//   err_o      sticky protocol-error flag (request edge while a word is pending)
//
// Build option
//   CDC_BUS_RX_ERR_EN  when defined, protocol-error detection is compiled in.
//                      When undefined, err_o is tied low. Stray request edges
//                      are ignored either way, so the data path is unchanged.

module cdc_bus_rx #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_tgl_i,
  input  logic [Width-1:0] data_i,
  output logic             ack_tgl_o,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             err_o
);

  typedef enum logic {
    IDLE,
    VALID
  } state_t;

  state_t           state_q, state_d;
  logic             req_meta, req_sync, req_prev;
  logic             req_edge;
  logic             capture, accept;
  logic [Width-1:0] data_q;
  logic             ack_q;

  // Two-flop synchronizer plus one history flop for edge detection.
  // req_meta feeds req_sync directly, so metastability has a full cycle to resolve.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_meta <= 1'b0;
      req_sync <= 1'b0;
      req_prev <= 1'b0;
    end else begin
      req_meta <= req_tgl_i;
      req_sync <= req_meta;
      req_prev <= req_sync;
    end
  end

  // Each level change of the request toggle is one request.
  assign req_edge = req_sync ^ req_prev;

  // Next-state logic and handshake decode.
  // An edge seen in VALID is deliberately not a capture.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    accept  = 1'b0;
    valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_edge) begin
          capture = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        valid_o = 1'b1;
        if (ready_i) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // data_i is sampled only in the capture cycle. The source protocol keeps
  // data_i stable across that cycle, so per-bit synchronizers are not needed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        data_q <= data_i;
      end
      if (accept) begin
        ack_q <= ~ack_q;
      end
    end
  end

  assign data_o    = data_q;
  assign ack_tgl_o = ack_q;

`ifdef CDC_BUS_RX_ERR_EN
  logic err_q;

  // Once set, the error flag stays set until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if ((state_q == VALID) && req_edge) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_bus_rx.sv
// tb_cdc_bus_rx
// -------------
// Testbench for cdc_bus_rx. A behavioural source pushes each word it launches
// into a scoreboard queue. A monitor on the falling edge pops a word whenever
// the DUT hands one over (valid_o && ready_i). The monitor also keeps a model of
// the acknowledge level, which is the parity of the words accepted since reset.
// It also checks that a stalled word stays put.

module tb_cdc_bus_rx;

  localparam int Width = 32;

`ifdef CDC_BUS_RX_ERR_EN
  localparam logic [31:0] ErrExp = 32'd1;
`else
  localparam logic [31:0] ErrExp = 32'd0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_tgl_i;
  logic [Width-1:0] data_i;
  logic             ack_tgl_o;
  logic [Width-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic             err_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] sb[$];
  bit          exp_ack     = 1'b0;
  bit          hold        = 1'b0;
  logic [31:0] hold_data   = '0;
  int          accept_cnt  = 0;
  int          ack_toggles = 0;
  logic        last_ack    = 1'b0;
  bit          src_req     = 1'b0;
  int          ready_mode  = 0;

  cdc_bus_rx #(.Width(Width)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_tgl_i (req_tgl_i),
    .data_i    (data_i),
    .ack_tgl_o (ack_tgl_o),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Source side: set data one cycle ahead, then flip the request toggle.
  task automatic applyStimulus(input logic [31:0] d, input bit push);
    @(posedge clk_i); #2;
    data_i = d;
    @(posedge clk_i); #2;
    src_req   = ~src_req;
    req_tgl_i = src_req;
    if (push) sb.push_back(d);
  endtask

  task automatic waitAck(input logic level, input int budget);
    for (int i = 0; i < budget && ack_tgl_o !== level; i++) @(negedge clk_i);
    checkOutput("ack_wait", {31'd0, ack_tgl_o}, {31'd0, level});
  endtask

  task automatic waitValid(input int budget);
    for (int i = 0; i < budget && valid_o !== 1'b1; i++) @(negedge clk_i);
    checkOutput("valid_wait", {31'd0, valid_o}, 32'd1);
  endtask

  task automatic coordinatedReset(input int cycles);
    @(posedge clk_i); #2;
    rst_i     = 1'b1;
    src_req   = 1'b0;
    req_tgl_i = 1'b0;
    repeat (cycles) @(posedge clk_i);
    #2 rst_i = 1'b0;
  endtask

  // Downstream ready driver. Mode 0 holds ready low, mode 1 holds it high,
  // and mode 2 drives a random value each cycle.
  initial begin
    ready_i = 1'b0;
    forever begin
      @(posedge clk_i); #2;
      case (ready_mode)
        0:       ready_i = 1'b0;
        1:       ready_i = 1'b1;
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  initial begin
    logic [31:0] exp_word;
    forever begin
      @(negedge clk_i);
      checkOutput("ack_level", {31'd0, ack_tgl_o}, {31'd0, exp_ack});
      if (ack_tgl_o !== last_ack) ack_toggles++;
      last_ack = ack_tgl_o;
      if (hold) begin
        checkOutput("hold_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("hold_data", data_o, hold_data);
      end
      if (rst_i === 1'b1) begin
        exp_ack = 1'b0;
        sb.delete();
        hold = 1'b0;
      end else begin
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL spurious_word: got %h expected no word", data_o);
          end else begin
            exp_word = sb.pop_front();
            if (data_o !== exp_word) begin
              bad++;
              $display("[TB] FAIL word: got %h expected %h", data_o, exp_word);
            end
          end
          exp_ack = ~exp_ack;
          accept_cnt++;
        end
        hold      = (valid_o === 1'b1) && (ready_i !== 1'b1);
        hold_data = data_o;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start_acc, start_tgl;
    rst_i     = 1'b1;
    req_tgl_i = 1'b0;
    data_i    = '0;

    // Reset and idle. ready_i is high while valid_o is low, which must be ignored.
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_data", data_o, 32'd0);
    checkOutput("rst_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("rst_ack", {31'd0, ack_tgl_o}, 32'd0);
    checkOutput("rst_err", {31'd0, err_o}, 32'd0);
    ready_mode = 1;
    repeat (20) begin
      @(negedge clk_i);
      checkOutput("idle_valid", {31'd0, valid_o}, 32'd0);
    end

    // Single transfer: the toggle is sampled at the next edge and valid_o
    // rises after the third edge.
    applyStimulus(32'hDEADBEEF, 1'b1);
    repeat (3) @(negedge clk_i);
    checkOutput("lat_valid_early", {31'd0, valid_o}, 32'd0);
    @(negedge clk_i);
    checkOutput("lat_valid", {31'd0, valid_o}, 32'd1);
    checkOutput("lat_data", data_o, 32'hDEADBEEF);
    @(negedge clk_i);
    checkOutput("one_cycle_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("single_ack", {31'd0, ack_tgl_o}, 32'd1);

    // Backpressure: ready_i is held low for 10 cycles.
    ready_mode = 0;
    applyStimulus(32'h0BADF00D, 1'b1);
    waitValid(20);
    repeat (10) begin
      @(negedge clk_i);
      checkOutput("bp_valid", {31'd0, valid_o}, 32'd1);
      checkOutput("bp_data", data_o, 32'h0BADF00D);
      checkOutput("bp_ack", {31'd0, ack_tgl_o}, 32'd1);
    end
    ready_mode = 1;
    waitAck(src_req, 20);

    // Stream of words 0x1..0x40 with random ready_i.
    ready_mode = 2;
    start_acc  = accept_cnt;
    start_tgl  = ack_toggles;
    for (int w = 1; w <= 64; w++) begin
      applyStimulus(32'(w), 1'b1);
      waitAck(src_req, 200);
    end
    repeat (3) @(negedge clk_i);
    checkOutput("stream_words", 32'(accept_cnt - start_acc), 32'd64);
    checkOutput("stream_acks", 32'(ack_toggles - start_tgl), 32'd64);
    checkOutput("stream_err", {31'd0, err_o}, 32'd0);

    // Reset while a word is pending. The word is dropped and no ack is issued.
    ready_mode = 0;
    applyStimulus(32'h55AA0001, 1'b1);
    waitValid(20);
    @(posedge clk_i); #2;
    rst_i     = 1'b1;
    src_req   = 1'b0;
    req_tgl_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("midrst_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("midrst_ack", {31'd0, ack_tgl_o}, 32'd0);
    @(posedge clk_i); #2 rst_i = 1'b0;
    repeat (6) @(negedge clk_i);
    checkOutput("postrst_valid", {31'd0, valid_o}, 32'd0);
    ready_mode = 1;
    applyStimulus(32'hA5A5A5A5, 1'b1);
    waitAck(src_req, 40);

    // Protocol violation: a second toggle arrives while a word is pending.
    ready_mode = 0;
    applyStimulus(32'hCAFE0001, 1'b1);
    waitValid(20);
    @(posedge clk_i); #2;
    data_i    = 32'h00001234;
    src_req   = ~src_req;
    req_tgl_i = src_req;
    repeat (6) @(negedge clk_i);
    checkOutput("viol_err", {31'd0, err_o}, ErrExp);
    checkOutput("viol_data", data_o, 32'hCAFE0001);
    checkOutput("viol_valid", {31'd0, valid_o}, 32'd1);
    ready_mode = 1;
    waitAck(~src_req, 20);
    repeat (10) @(negedge clk_i);
    checkOutput("viol_one_ack", {31'd0, ack_tgl_o}, {31'd0, ~src_req});
    checkOutput("viol_err_sticky", {31'd0, err_o}, ErrExp);

    // Coordinated reset clears the error, then a clean transfer follows.
    coordinatedReset(2);
    @(negedge clk_i);
    checkOutput("final_rst_err", {31'd0, err_o}, 32'd0);
    checkOutput("final_rst_ack", {31'd0, ack_tgl_o}, 32'd0);
    applyStimulus(32'h0000FFFF, 1'b1);
    waitAck(src_req, 40);

    repeat (5) @(negedge clk_i);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
